// File: rtl/fml_ddr3_psync_arb_if.sv
// Handshake bundle between the local requesters, the shared toggle synchroniser and the
// crossing arbiter.
interface fml_ddr3_psync_arb_if;
  logic [3:0] req_i;
  logic       done_i;
  logic       err_clr_i;
  logic       psync_o;
  logic [1:0] chan_o;
  logic       busy_o;
  logic [3:0] pending_o;
  logic [3:0] done_o;
  logic       timeout_o;
  logic       ovf_o;

  // Arbiter side.
  modport master (
    input  req_i, done_i, err_clr_i,
    output psync_o, chan_o, busy_o, pending_o, done_o, timeout_o, ovf_o
  );

  // Requester / environment side.
  modport slave (
    output req_i, done_i, err_clr_i,
    input  psync_o, chan_o, busy_o, pending_o, done_o, timeout_o, ovf_o
  );
endinterface

// File: rtl/fml_ddr3_psync_arb.sv
// Round-robin arbiter serialising four request channels onto one shared pulse synchroniser,
// with acknowledge timeout, post-crossing guard gap and sticky error flags.
module fml_ddr3_psync_arb #(
  parameter int unsigned GAP     = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  fml_ddr3_psync_arb_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  localparam logic [3:0] GapLoad = 4'(GAP);

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] last_q, last_d;
  logic [1:0] chan_q, chan_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] done_q, done_d;
  logic       psync_q, psync_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic       ovf_q, ovf_d;
  logic [3:0] clr_mask;
  logic [1:0] pick, idx;

  // Descending scan so the channel closest after last_q overrides the others.
  always_comb begin
    pick = last_q + 2'd1;
    idx  = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = last_q + 2'(i) + 2'd1;
      if (pending_q[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    psync_d  = 1'b0;
    done_d   = '0;
    clr_mask = '0;
    tmo_d    = tmo_q & ~bus.err_clr_i;
    ovf_d    = ovf_q & ~bus.err_clr_i;

    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          chan_d  = pick;
          psync_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        clr_mask = 4'b0001 << chan_q;
        last_d   = chan_q;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        // An acknowledge on the expiry cycle still counts as a completion.
        if (bus.done_i) begin
          done_d  = 4'b0001 << chan_q;
          gap_d   = GapLoad;
          state_d = StGap;
        end else if (cnt_q == TmoLast) begin
          tmo_d   = 1'b1;
          gap_d   = GapLoad;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == 4'd0) state_d = StIdle;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase

    if (|(bus.req_i & pending_q & ~clr_mask)) ovf_d = 1'b1;
    pending_d = (pending_q & ~clr_mask) | bus.req_i;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      last_q    <= 2'd3;
      chan_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      done_q    <= '0;
      psync_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      psync_q   <= psync_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.psync_o   = psync_q;
  assign bus.chan_o    = chan_q;
  assign bus.busy_o    = busy_q;
  assign bus.pending_o = pending_q;
  assign bus.done_o    = done_q;
  assign bus.timeout_o = tmo_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_fml_ddr3_psync_arb.sv
// Scenario bench for fml_ddr3_psync_arb: expected issues/completions are queued as stimulus
// is driven and matched by a monitor as the arbiter produces them.
module tb_fml_ddr3_psync_arb;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [1:0] exp_issue[$];
  logic [3:0] exp_done[$];

  fml_ddr3_psync_arb_if bus ();

  fml_ddr3_psync_arb #(
    .GAP    (3),
    .TIMEOUT(8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Scoreboard: every psync_o and done_o pulse must match the head of its queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.psync_o === 1'b1) begin
        n_checks++;
        if (exp_issue.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected: psync_o with chan_o=%0d, no issue expected",
                   bus.chan_o);
        end else begin
          logic [1:0] e;
          e = exp_issue.pop_front();
          if (bus.chan_o !== e) begin
            n_fail++;
            $display("FAIL issue_chan: got chan_o=%0d expected %0d", bus.chan_o, e);
          end
        end
      end
      if (bus.done_o !== 4'b0000) begin
        n_checks++;
        if (exp_done.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: done_o=%b, no completion expected", bus.done_o);
        end else begin
          logic [3:0] e;
          e = exp_done.pop_front();
          if (bus.done_o !== e) begin
            n_fail++;
            $display("FAIL done_onehot: got done_o=%b expected %b", bus.done_o, e);
          end
        end
      end
    end
  end

  function automatic logic [13:0] obs();
    return {bus.psync_o, bus.chan_o, bus.busy_o, bus.pending_o, bus.done_o,
            bus.timeout_o, bus.ovf_o};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy_o !== 1'b0 && t < 60) begin
      step();
      t++;
    end
  endtask

  // Waits (bounded) for the next issue, then acknowledges it two cycles later.
  task automatic ack_next(output bit ok);
    int t = 0;
    while (bus.psync_o !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    ok = (bus.psync_o === 1'b1);
    if (ok) begin
      step(2);
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    step(2);
    n_checks++;
    if (obs() !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    sys_rst_n = 1'b1;
    step(2);
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.psync_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b psync=%b expected 0 0", bus.busy_o,
               bus.psync_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      exp_issue.push_back(2'(k));
      exp_done.push_back(4'b0001 << k);
    end
    bus.req_i = 4'b1111;
    step();
    bus.req_i = 4'b0000;
    n_checks++;
    if (bus.pending_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL rr_pending: got %b expected 1111", bus.pending_o);
    end
    for (int k = 0; k < 4; k++) begin
      ack_next(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rr_issue_%0d: psync_o=0 after wait budget expected 1", k);
      end
    end
    wait_idle();
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.pending_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_drained: busy=%b pending=%b expected 0 0000", bus.busy_o,
               bus.pending_o);
    end
  endtask

  task automatic test_single();
    exp_issue.push_back(2'd0);
    exp_done.push_back(4'b0001);
    bus.req_i = 4'b0001;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    n_checks++;
    if (bus.pending_o !== 4'b0001 || bus.psync_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_e0: pending=%b psync=%b expected 0001 0", bus.pending_o,
               bus.psync_o);
    end
    step();                                       // edge 1
    n_checks++;
    if (bus.psync_o !== 1'b1 || bus.chan_o !== 2'd0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_e1: psync=%b chan=%0d busy=%b expected 1 0 1", bus.psync_o,
               bus.chan_o, bus.busy_o);
    end
    step();                                       // edge 2
    n_checks++;
    if (bus.psync_o !== 1'b0 || bus.pending_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_e2: psync=%b pending=%b expected 0 0000", bus.psync_o,
               bus.pending_o);
    end
    step(3);                                      // edge 5
    bus.done_i = 1'b1;
    step();                                       // edge 6
    bus.done_i = 1'b0;
    n_checks++;
    if (bus.done_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_done_e6: got %b expected 0001", bus.done_o);
    end
    step();                                       // edge 7
    n_checks++;
    if (bus.done_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done_e7: got %b expected 0000", bus.done_o);
    end
    step(2);                                      // edge 9
    n_checks++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_e9: got %b expected 1", bus.busy_o);
    end
    step();                                       // edge 10
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_e10: got %b expected 0", bus.busy_o);
    end
  endtask

  task automatic test_coalesce();
    bit ok;
    exp_issue.push_back(2'd0);
    exp_issue.push_back(2'd2);
    exp_done.push_back(4'b0001);
    exp_done.push_back(4'b0100);
    bus.req_i = 4'b0001;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    step();                                       // edge 1: ch0 issued
    bus.req_i = 4'b0100;
    step();                                       // edge 2
    bus.req_i = 4'b0000;
    n_checks++;
    if (bus.pending_o !== 4'b0100 || bus.ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL coal_first: pending=%b ovf=%b expected 0100 0", bus.pending_o,
               bus.ovf_o);
    end
    step();                                       // edge 3
    bus.req_i = 4'b0100;
    step();                                       // edge 4
    bus.req_i = 4'b0000;
    n_checks++;
    if (bus.pending_o !== 4'b0100 || bus.ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL coal_second: pending=%b ovf=%b expected 0100 1", bus.pending_o,
               bus.ovf_o);
    end
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    ack_next(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL coal_issue_ch2: psync_o=0 after wait budget expected 1");
    end
    wait_idle();
    step(5);
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.pending_o !== 4'b0000 || bus.ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL coal_after: busy=%b pending=%b ovf=%b expected 0 0000 1", bus.busy_o,
               bus.pending_o, bus.ovf_o);
    end
    bus.err_clr_i = 1'b1;
    step();
    bus.err_clr_i = 1'b0;
    n_checks++;
    if (bus.ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL coal_clear: ovf=%b expected 0", bus.ovf_o);
    end
  endtask

  task automatic test_timeout();
    exp_issue.push_back(2'd1);
    bus.req_i = 4'b0010;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    step(9);                                      // edge 9
    n_checks++;
    if (bus.timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: timeout=%b expected 0 at edge 9", bus.timeout_o);
    end
    step();                                       // edge 10
    n_checks++;
    if (bus.timeout_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_fire: timeout=%b busy=%b expected 1 1", bus.timeout_o, bus.busy_o);
    end
    step(3);                                      // edge 13
    n_checks++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_gap_e13: busy=%b expected 1", bus.busy_o);
    end
    step();                                       // edge 14
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_gap_e14: busy=%b expected 0", bus.busy_o);
    end
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    step();
    n_checks++;
    if (bus.done_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_stray_done: done=%b busy=%b timeout=%b expected 0000 0 1",
               bus.done_o, bus.busy_o, bus.timeout_o);
    end
    bus.err_clr_i = 1'b1;
    step();
    bus.err_clr_i = 1'b0;
    n_checks++;
    if (bus.timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: timeout=%b expected 0", bus.timeout_o);
    end
    // Acknowledge arriving exactly on the expiry cycle.
    exp_issue.push_back(2'd1);
    exp_done.push_back(4'b0010);
    bus.req_i = 4'b0010;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    step(9);                                      // edge 9
    bus.done_i = 1'b1;
    step();                                       // edge 10
    bus.done_i = 1'b0;
    n_checks++;
    if (bus.done_o !== 4'b0010 || bus.timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_edge_ack: done=%b timeout=%b expected 0010 0", bus.done_o,
               bus.timeout_o);
    end
    wait_idle();
  endtask

  task automatic test_race();
    bit ok;
    exp_issue.push_back(2'd1);
    exp_issue.push_back(2'd1);
    exp_done.push_back(4'b0010);
    exp_done.push_back(4'b0010);
    bus.req_i = 4'b0010;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    step();                                       // edge 1: issue ch1
    bus.req_i = 4'b0010;
    step();                                       // edge 2: clear and set collide
    bus.req_i = 4'b0000;
    n_checks++;
    if (bus.pending_o !== 4'b0010 || bus.ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL race_pending: pending=%b ovf=%b expected 0010 0", bus.pending_o,
               bus.ovf_o);
    end
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    ack_next(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL race_reissue: psync_o=0 after wait budget expected 1");
    end
    wait_idle();
    n_checks++;
    if (bus.pending_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL race_drained: pending=%b busy=%b expected 0000 0", bus.pending_o,
               bus.busy_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_issue.push_back(2'd0);
    bus.req_i = 4'b0001;
    step();                                       // edge 0
    bus.req_i = 4'b0000;
    step(3);                                      // edge 3: in WAIT
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected 0", obs());
    end
    step();
    #2 sys_rst_n = 1'b1;
    step();
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    n_checks++;
    if (obs() !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_late_done: got %h expected 0", obs());
    end
    step(3);
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_settled: busy=%b done=%b expected 0 0000", bus.busy_o, bus.done_o);
    end
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    bus.req_i     = 4'b0000;
    bus.done_i    = 1'b0;
    bus.err_clr_i = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_coalesce();
    test_timeout();
    test_race();
    test_reset_mid_wait();
    n_checks++;
    if (exp_issue.size() != 0 || exp_done.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d issues and %0d completions outstanding expected 0 0",
               exp_issue.size(), exp_done.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
